pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Owns the program counter of the pipelined MIPS core and decides each cycle's next fetch address: sequential PC+4, a conditional-branch target, a J/JAL jump target, or a JR register target. Control decisions resolve in ID. The block holds the PC under hazard stalls and flushes IF/ID on every taken redirect. A redirect that arrives while the front end is stalled is captured and replayed, not lost. A halt request freezes fetch.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- stall  in  1  hazard unit: hold PC and IF/ID this cycle
- pc_plus4_id  in  32  PC+4 of the instruction currently in ID
- branch_taken_id  in  1  ID-stage branch resolved taken
- branch_imm_id  in  16  branch immediate from the ID instruction
- jump_id  in  1  J/JAL in ID
- instr_index_id  in  26  jump index field from the ID instruction
- jr_id  in  1  JR in ID
- rs_value_id  in  32  forwarded rs value for JR
- halt_id  in  1  halt instruction decoded in ID
- pc  out  32  current fetch address
- pc_plus4  out  32  pc + 4; wraps modulo 2^32
- if_id_flush  out  1  clear the IF/ID register at the next edge
- halted  out  1  fetch frozen

## Operation
- States: RUN, HOLD, HALT. Reset sets state to RUN, pc to RESET_PC, the pending register to 0, and pending_valid to 0.
- Target selection uses fixed priority jr_id > jump_id > branch_taken_id.
  - JR target: rs_value_id.
  - Jump target: {pc_plus4_id[31:28], instr_index_id, 2'b00}.
  - Branch target: pc_plus4_id + (sign_extend(branch_imm_id) << 2), truncated to 32 bits.
- redirect = jr_id | jump_id | branch_taken_id.
- RUN, stall=0, redirect=1: pc <= target; if_id_flush=1.
- RUN, stall=0, redirect=0: pc <= pc_plus4; if_id_flush=0.
- RUN, stall=1, redirect=0: pc holds.
- RUN, stall=1, redirect=1: pc holds; pending <= target; pending_valid=1; go to HOLD; if_id_flush=0.
- HOLD, stall=1: pc holds; pending is not overwritten by new ID inputs.
- HOLD, stall=0: pc <= pending; if_id_flush=1; pending_valid cleared; go to RUN. ID inputs are ignored in this cycle.
- halt_id is recognised only when stall=0 and the block is in RUN. It then takes priority over redirect:
  - pc holds;
  - if_id_flush=1;
  - go to HALT.
- HALT: pc frozen, halted=1, if_id_flush=0. Every input except reset is ignored. Only reset leaves HALT.
- Branch and JR target bits [1:0] are passed through unchanged; no alignment check.

## Timing
- pc, state, pending and pending_valid are registered.
- pc_plus4, if_id_flush and halted are combinational from state and the current inputs.
- Redirect latency: redirect seen in cycle n with stall=0 → pc equals target in cycle n+1. The IF/ID flush occurs at the same edge.
- Redirect under stall: if stall deasserts in cycle m, the pending target appears on pc in cycle m+1.
- Reset has priority over every other input in any state, including HOLD with a pending redirect; the pending redirect is discarded.
- In the reset cycle and the cycle after it, if_id_flush=0 and halted=0.
- pc_plus4 of 32'hFFFF_FFFC is 32'h0000_0000.

## Structure
- Shared package holds:
  - the state encoding (RUN=2'd0, HOLD=2'd1, HALT=2'd2);
  - the default RESET_PC;
  - the PC width constant 32.
- One sub-module, pc_target_calc, is purely combinational. It computes the jump, branch and JR targets and applies the priority mux. This lets the verification engineer check target arithmetic in isolation.
- The top level holds the PC register, the pending register and the FSM.

## Test plan
- Reset with RESET_PC=32'h0040_0000 → pc=32'h0040_0000, pc_plus4=32'h0040_0004, if_id_flush=0, halted=0. Three idle cycles → pc=32'h0040_000C.
- jump_id=1, instr_index_id=26'h010_0008, pc_plus4_id=32'h0040_0010, stall=0 → if_id_flush=1 that cycle; next cycle pc=32'h0040_0020.
- branch_taken_id=1, branch_imm_id=16'hFFFE, pc_plus4_id=32'h0040_0024 → next pc=32'h0040_001C.
- Simultaneous jr_id=1 (rs_value_id=32'h0040_0100) and branch_taken_id=1, stall=0 → next pc=32'h0040_0100, branch ignored.
- Redirect to 32'h0040_0200 while stall=1 for 3 cycles:
  - pc holds and if_id_flush=0 throughout;
  - ID inputs changed mid-stall are ignored;
  - in the stall-release cycle if_id_flush=1;
  - next pc=32'h0040_0200.
- Two halt cases:
  - halt_id with stall=0 → next cycle halted=1; pc frozen for 10 cycles despite jump_id=1.
  - Reset during HOLD with a pending target → pc=RESET_PC and pending discarded (no flush after stall drops).

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared state encoding and PC constants for pc_sequencer
package pc_sequencer_pkg;

  localparam int PC_W = 32;
  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HOLD = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/pc_target_calc.sv
// rtl/pc_target_calc.sv - ID-stage redirect target arithmetic and priority select
module pc_target_calc
  import pc_sequencer_pkg::*;
(
  input  logic [PC_W-1:0] pc_plus4_id,
  input  logic            branch_taken_id,
  input  logic [15:0]     branch_imm_id,
  input  logic            jump_id,
  input  logic [25:0]     instr_index_id,
  input  logic            jr_id,
  input  logic [PC_W-1:0] rs_value_id,
  output logic [PC_W-1:0] target,
  output logic            redirect
);

  logic [PC_W-1:0] jump_target;
  logic [PC_W-1:0] branch_target;

  assign jump_target   = {pc_plus4_id[31:28], instr_index_id, 2'b00};
  // Sign-extended word offset; the add wraps at 32 bits.
  assign branch_target = pc_plus4_id + {{14{branch_imm_id[15]}}, branch_imm_id, 2'b00};

  assign redirect = jr_id | jump_id | branch_taken_id;

  always_comb begin
    target = branch_target;
    if (jr_id)
      target = rs_value_id;
    else if (jump_id)
      target = jump_target;
  end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter register, stalled-redirect replay and halt FSM
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic [PC_W-1:0] pc_plus4_id,
  input  logic            branch_taken_id,
  input  logic [15:0]     branch_imm_id,
  input  logic            jump_id,
  input  logic [25:0]     instr_index_id,
  input  logic            jr_id,
  input  logic [PC_W-1:0] rs_value_id,
  input  logic            halt_id,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc_plus4,
  output logic            if_id_flush,
  output logic            halted
);

  state_t          state, state_next;
  logic [PC_W-1:0] pc_next;
  logic [PC_W-1:0] pending, pending_next;
  logic            pending_valid, pending_valid_next;
  logic [PC_W-1:0] target;
  logic            redirect;

  pc_target_calc u_target (
    .pc_plus4_id     (pc_plus4_id),
    .branch_taken_id (branch_taken_id),
    .branch_imm_id   (branch_imm_id),
    .jump_id         (jump_id),
    .instr_index_id  (instr_index_id),
    .jr_id           (jr_id),
    .rs_value_id     (rs_value_id),
    .target          (target),
    .redirect        (redirect)
  );

  assign pc_plus4 = pc + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_RUN;
      pc            <= RESET_PC;
      pending       <= '0;
      pending_valid <= 1'b0;
    end else begin
      state         <= state_next;
      pc            <= pc_next;
      pending       <= pending_next;
      pending_valid <= pending_valid_next;
    end
  end

  // Outputs are masked while reset is asserted so a reset out of HALT/HOLD is clean.
  always_comb begin
    state_next         = state;
    pc_next            = pc;
    pending_next       = pending;
    pending_valid_next = pending_valid;
    if_id_flush        = 1'b0;
    halted             = 1'b0;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (!stall) begin
            if (halt_id) begin
              if_id_flush = 1'b1;
              state_next  = ST_HALT;
            end else if (redirect) begin
              pc_next     = target;
              if_id_flush = 1'b1;
            end else begin
              pc_next = pc_plus4;
            end
          end else if (redirect) begin
            pending_next       = target;
            pending_valid_next = 1'b1;
            state_next         = ST_HOLD;
          end
        end
        ST_HOLD: begin
          // ID inputs are stale here; only the captured target is replayed.
          if (!stall && pending_valid) begin
            pc_next            = pending;
            if_id_flush        = 1'b1;
            pending_valid_next = 1'b0;
            state_next         = ST_RUN;
          end
        end
        ST_HALT: begin
          halted = 1'b1;
        end
        default: begin
          state_next = ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with directed and random phases
module tb_pc_sequencer;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic [31:0] pc_plus4_id = '0;
  logic        branch_taken_id = 1'b0;
  logic [15:0] branch_imm_id = '0;
  logic        jump_id = 1'b0;
  logic [25:0] instr_index_id = '0;
  logic        jr_id = 1'b0;
  logic [31:0] rs_value_id = '0;
  logic        halt_id = 1'b0;
  logic [31:0] pc, pc_plus4;
  logic        if_id_flush, halted;

  pc_sequencer #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_plus4_id(pc_plus4_id),
    .branch_taken_id(branch_taken_id), .branch_imm_id(branch_imm_id),
    .jump_id(jump_id), .instr_index_id(instr_index_id), .jr_id(jr_id),
    .rs_value_id(rs_value_id), .halt_id(halt_id), .pc(pc), .pc_plus4(pc_plus4),
    .if_id_flush(if_id_flush), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        flush;
    logic        halted;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  // Reference model: architectural PC, a queue holding at most one deferred target, halt flag.
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  bit          m_halted;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc", pc, e.pc);
      chk("pc_plus4", pc_plus4, e.pc4);
      chk("if_id_flush", {31'd0, if_id_flush}, {31'd0, e.flush});
      chk("halted", {31'd0, halted}, {31'd0, e.halted});
    end
  end

  function automatic logic [31:0] model_target();
    int signed off;
    if (jr_id) return rs_value_id;
    if (jump_id) return (pc_plus4_id & 32'hF000_0000) | (32'(instr_index_id) * 4);
    off = int'($signed(branch_imm_id)) * 4;
    return pc_plus4_id + 32'(off);
  endfunction

  task automatic step();
    exp_t        e;
    logic [31:0] tgt;
    bit          redir;
    redir    = jr_id | jump_id | branch_taken_id;
    tgt      = model_target();
    e.pc     = m_pc;
    e.pc4    = m_pc + 32'd4;
    e.flush  = 1'b0;
    e.halted = 1'b0;
    if (reset) begin
      m_pc     = RST_PC;
      m_halted = 0;
      m_pend.delete();
    end else if (m_halted) begin
      e.halted = 1'b1;
    end else if (m_pend.size() != 0) begin
      if (!stall) begin
        e.flush = 1'b1;
        m_pc    = m_pend.pop_front();
      end
    end else if (stall) begin
      if (redir) m_pend.push_back(tgt);
    end else if (halt_id) begin
      e.flush  = 1'b1;
      m_halted = 1;
    end else if (redir) begin
      e.flush = 1'b1;
      m_pc    = tgt;
    end else begin
      m_pc = m_pc + 32'd4;
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; stall = 0; branch_taken_id = 0; jump_id = 0; jr_id = 0; halt_id = 0;
  endtask

  task automatic randomize_id();
    pc_plus4_id    = $urandom;
    branch_imm_id  = 16'($urandom);
    instr_index_id = 26'($urandom);
    rs_value_id    = $urandom;
  endtask

  initial begin
    bit prev_reset;
    @(posedge clk); #1;
    m_pc = RST_PC; m_halted = 0;

    // Reset cycle, then three idle fetches.
    reset = 1; step();
    idle();
    repeat (3) step();
    chk("tp_idle_pc", pc, 32'h0040_000C);

    jump_id = 1; instr_index_id = 26'h010_0008; pc_plus4_id = 32'h0040_0010;
    step(); idle();
    chk("tp_jump_pc", pc, 32'h0040_0020);

    branch_taken_id = 1; branch_imm_id = 16'hFFFE; pc_plus4_id = 32'h0040_0024;
    step(); idle();
    chk("tp_branch_pc", pc, 32'h0040_001C);

    jr_id = 1; rs_value_id = 32'h0040_0100; branch_taken_id = 1; branch_imm_id = 16'h0010;
    step(); idle();
    chk("tp_jr_prio_pc", pc, 32'h0040_0100);

    // Redirect captured under a three-cycle stall; mid-stall ID changes must be ignored.
    stall = 1; jr_id = 1; rs_value_id = 32'h0040_0200;
    step();
    jr_id = 0; jump_id = 1; instr_index_id = 26'h3FF_FFFF; rs_value_id = 32'h1234_5678;
    step();
    jump_id = 0; branch_taken_id = 1; branch_imm_id = 16'h7FFF;
    step();
    idle(); step();
    chk("tp_hold_replay_pc", pc, 32'h0040_0200);

    halt_id = 1; step(); idle();
    for (int i = 0; i < 10; i++) begin
      jump_id = 1; instr_index_id = 26'($urandom); stall = 1'($urandom_range(0, 1));
      step();
    end
    chk("tp_halt_frozen_pc", pc, 32'h0040_0200);

    idle(); reset = 1; step(); idle(); step();
    stall = 1; jump_id = 1; instr_index_id = 26'h000_0100; pc_plus4_id = 32'h0040_0008;
    step();
    reset = 1; step();
    idle(); step();
    chk("tp_reset_drops_pending", pc, RST_PC + 32'd4);

    // Wraparound of pc_plus4 at the top of the address space.
    jr_id = 1; rs_value_id = 32'hFFFF_FFFC; step(); idle(); step();
    chk("tp_wrap_pc", pc, 32'h0000_0000);

    prev_reset = 0;
    for (int i = 0; i < 400; i++) begin
      randomize_id();
      reset = ($urandom_range(0, 99) < (m_halted ? 15 : 2));
      if (prev_reset) begin
        idle();
      end else begin
        stall           = ($urandom_range(0, 99) < 35);
        jr_id           = ($urandom_range(0, 99) < 15);
        jump_id         = ($urandom_range(0, 99) < 20);
        branch_taken_id = ($urandom_range(0, 99) < 25);
        halt_id         = ($urandom_range(0, 99) < 3);
      end
      prev_reset = reset;
      step();
    end
    idle(); step();
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
